// File: rtl/tick_dispatcher.sv
// Turns upstream tick pulses into four-phase req/ack handshakes,
// queueing ticks while busy and aborting stalled handshakes.
module tick_dispatcher #(
  parameter int MAXP  = 3,
  parameter int PBITS = 2,
  parameter int TMO   = 15,
  parameter int TBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ack,
  output logic             req,
  output logic             done,
  output logic [PBITS-1:0] pend,
  output logic             ovf,
  output logic             tmo_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [TBITS-1:0] timer;
  logic [PBITS-1:0] pend_n;
  logic             expire;
  logic             deq;
  logic             enq;
  logic             abort;
  logic             finish;
  logic             ovf_set;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    expire  = (timer == TBITS'(TMO - 1));
    state_n = state;
    unique case (state)
      S_IDLE: if (pend != '0 || tick) state_n = S_REQ;
      S_REQ: begin
        if (ack)         state_n = S_REL;
        else if (expire) state_n = S_IDLE;
      end
      S_REL: begin
        if (!ack)        state_n = S_IDLE;
        else if (expire) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A tick is consumed directly only when idle with nothing queued.
  always_comb begin
    deq     = (state == S_IDLE) && (pend != '0);
    enq     = tick && !((state == S_IDLE) && (pend == '0));
    finish  = (state == S_REL) && !ack;
    abort   = ((state == S_REQ) && !ack && expire) ||
              ((state == S_REL) && ack && expire);
    pend_n  = pend;
    ovf_set = 1'b0;
    if (enq && !deq) begin
      if (pend == PBITS'(MAXP)) ovf_set = 1'b1;
      else                      pend_n  = pend + 1'b1;
    end else if (deq && !enq) begin
      pend_n = pend - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req     <= 1'b0;
      done    <= 1'b0;
      pend    <= '0;
      ovf     <= 1'b0;
      tmo_err <= 1'b0;
      timer   <= '0;
    end else begin
      req     <= (state_n == S_REQ);
      done    <= finish;
      pend    <= pend_n;
      ovf     <= ovf | ovf_set;
      tmo_err <= tmo_err | abort;
      if (state_n != state || state == S_IDLE) timer <= '0;
      else                                    timer <= timer + 1'b1;
    end
  end

  a_pend_max: assert property (
    @(posedge clk) disable iff (rst) pend <= PBITS'(MAXP));

`ifdef FORMAL
  a_live: assert property (
    @(posedge clk) s_eventually (!rst implies (done || tmo_err || pend == '0)));
`endif

endmodule

// File: tb/tb_tick_dispatcher.sv
// Bench for tick_dispatcher: vector table through a scoreboard
// queue, plus hand sequences for overflow, timeouts and reset.
module tb_tick_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       ack;
  logic       req;
  logic       done;
  logic [1:0] pend;
  logic       ovf;
  logic       tmo_err;

  int ncmp = 0;
  int nerr = 0;

  tick_dispatcher #(
    .MAXP(3), .PBITS(2), .TMO(15), .TBITS(4)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ack(ack),
    .req(req), .done(done), .pend(pend),
    .ovf(ovf), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic       done;
    logic [1:0] pend;
    logic       ovf;
    logic       tmo;
  } exp_t;

  typedef struct {
    logic tick;
    logic ack;
    exp_t e;
  } vec_t;

  vec_t tbl[19];
  exp_t sbq[$];

  function automatic vec_t mk(input logic t, input logic a,
                              input logic r, input logic d,
                              input logic [1:0] p);
    vec_t v;
    v.tick  = t;
    v.ack   = a;
    v.e     = '{req: r, done: d, pend: p, ovf: 1'b0, tmo: 1'b0};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic a);
    rst  = r;
    tick = t;
    ack  = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  logic [1:0] ep2[6];
  logic [1:0] pat[3];
  exp_t       got;
  exp_t       want;
  int         reqcnt;
  int         ndone;
  logic       ack_v;
  logic       chkreq;
  logic       sawdone;

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 1, 0, 0);
    tbl[9]  = mk(1, 0, 1, 0, 1);
    tbl[10] = mk(0, 1, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 1, 1);
    tbl[12] = mk(1, 0, 1, 0, 1);
    tbl[13] = mk(0, 1, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 1, 1);
    tbl[15] = mk(0, 0, 1, 0, 0);
    tbl[16] = mk(0, 1, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 1, 0);
    tbl[18] = mk(0, 0, 0, 0, 0);

    rst = 1'b1; tick = 1'b1; ack = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b1, 1'b1);
    chk("rst_state", {req, done, pend, ovf, tmo_err}, 6'b0);

    // single handshake, then queued tick and same-cycle tick in IDLE
    for (int i = 0; i < 19; i++) begin
      rst  = 1'b0;
      tick = tbl[i].tick;
      ack  = tbl[i].ack;
      sbq.push_back(tbl[i].e);
      @(posedge clk);
      #1;
      want = sbq.pop_front();
      got  = '{req: req, done: done, pend: pend, ovf: ovf, tmo: tmo_err};
      chk($sformatf("vec%0d", i), got, want);
    end

    // overflow and REQ timeout
    do_reset();
    ep2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk($sformatf("ovf_pend%0d", i), pend, ep2[i]);
      chk($sformatf("ovf_flag%0d", i), ovf, (i >= 4));
      chk($sformatf("ovf_req%0d", i), req, 1);
    end
    for (int k = 7; k <= 15; k++) step(1'b0, 1'b0, 1'b0);
    chk("tmo_req_last", {req, tmo_err}, 2'b10);
    step(1'b0, 1'b0, 1'b0);
    chk("tmo_abort", {req, done, tmo_err, pend}, 5'b00111);
    step(1'b0, 1'b0, 1'b0);
    chk("tmo_resume", {req, pend}, 3'b110);

    // three back-to-back handshakes with a reactive consumer
    do_reset();
    reqcnt = 0; ndone = 0; ack_v = 1'b0; chkreq = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (req) reqcnt++;
      else     reqcnt = 0;
      if (req && reqcnt >= 2) ack_v = 1'b1;
      else if (!req)          ack_v = 1'b0;
      step(1'b0, (c < 3), ack_v);
      if (chkreq) chk("b2b_next_req", req, 1);
      chkreq = done && (pend != 2'd0);
      if (done) begin
        if (ndone < 3) pat[ndone] = pend;
        ndone++;
      end
    end
    chk("b2b_ndone", ndone, 3);
    if (ndone >= 3) begin
      chk("b2b_pend0", pat[0], 2);
      chk("b2b_pend1", pat[1], 1);
      chk("b2b_pend2", pat[2], 0);
    end
    chk("b2b_flags", {ovf, tmo_err}, 2'b00);

    // ack stuck high in RELEASE
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("rel_enter", {req, pend}, 3'b001);
    sawdone = 1'b0;
    for (int k = 3; k <= 16; k++) begin
      step(1'b0, 1'b0, 1'b1);
      sawdone = sawdone | done;
    end
    chk("rel_pre_tmo", {req, tmo_err}, 2'b00);
    step(1'b0, 1'b0, 1'b1);
    sawdone = sawdone | done;
    chk("rel_tmo", {req, tmo_err, pend}, 4'b0101);
    chk("rel_no_done", sawdone, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("rel_service", {req, pend, tmo_err}, 4'b1001);

    // reset mid-handshake with queued ticks and sticky error set
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("mid_pre", {req, pend, tmo_err}, 4'b1101);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_rst", {req, done, pend, ovf, tmo_err}, 6'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("mid_rst_tick_drop", {req, pend}, 3'b000);
    step(1'b0, 1'b1, 1'b0);
    chk("mid_post_req", {req, pend}, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
